// File: rtl/pkt_capture_stats_n.sv
// pkt_capture_stats_n: one-stage packet pipeline with per-port capture
// statistics. Words pass through with one cycle of latency. An IOQ module
// header selects the source port. That port may be dropped, which suppresses
// every word of the packet from the IOQ header onward. It may also be counted:
// packets, bytes, first and last timestamp.
// Optional feature: define PKT_CAPTURE_MINMAX_EN to track the minimum and
// maximum packet length per port. When it is undefined, min_len reads all
// ones and max_len reads zero.
module pkt_capture_stats_n #(
    parameter int                    DATA_WIDTH         = 64,
    parameter int                    CTRL_WIDTH         = DATA_WIDTH / 8,
    parameter int                    NUM_PORTS          = 4,
    parameter logic [CTRL_WIDTH-1:0] IO_QUEUE_STAGE_NUM = 8'hff,
    parameter logic [CTRL_WIDTH-1:0] TIMESTAMP_CTRL     = 8'hfe,
    parameter int                    BYTE_CNT_WIDTH     = 40,
    parameter int                    TIME_WIDTH         = 64
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [DATA_WIDTH-1:0]              in_data,
    input  logic [CTRL_WIDTH-1:0]              in_ctrl,
    input  logic                               in_wr,
    output logic                               in_rdy,
    output logic [DATA_WIDTH-1:0]              out_data,
    output logic [CTRL_WIDTH-1:0]              out_ctrl,
    output logic                               out_wr,
    input  logic                               out_rdy,
    input  logic [NUM_PORTS-1:0]               enable,
    input  logic [NUM_PORTS-1:0]               drop,
    input  logic                               clear,
    output logic [NUM_PORTS*32-1:0]            pkt_cnt,
    output logic [NUM_PORTS*BYTE_CNT_WIDTH-1:0] byte_cnt,
    output logic [NUM_PORTS*TIME_WIDTH-1:0]    time_first,
    output logic [NUM_PORTS*TIME_WIDTH-1:0]    time_last,
    output logic [NUM_PORTS*16-1:0]            min_len,
    output logic [NUM_PORTS*16-1:0]            max_len
);

    localparam logic [CTRL_WIDTH-1:0] CTRL_ZERO = {CTRL_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_HDR     = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DROP    = 2'd2
    } state_t;

    state_t                      state_r, state_nxt_s;
    logic [DATA_WIDTH-1:0]       out_data_r;
    logic [CTRL_WIDTH-1:0]       out_ctrl_r;
    logic                        out_wr_r;
    logic [15:0]                 src_s;
    logic [2:0]                  port_s;
    logic                        match_s, drop_sel_s, en_sel_s;
    logic                        is_ioq_s, is_ts_s, eop_s, hdr_drop_s;
    logic [2:0]                  port_r;
    logic [15:0]                 len_r;
    logic                        match_r, en_r, drop_r, hdr_valid_r;
    logic [TIME_WIDTH-1:0]       ts_r;
    logic                        ts_valid_r;
    logic                        upd_r, upd_ts_valid_r;
    logic [2:0]                  upd_port_r;
    logic [15:0]                 upd_len_r;
    logic [TIME_WIDTH-1:0]       upd_ts_r;
    logic [NUM_PORTS*32-1:0]             pkt_cnt_r;
    logic [NUM_PORTS*BYTE_CNT_WIDTH-1:0] byte_cnt_r;
    logic [NUM_PORTS*TIME_WIDTH-1:0]     time_first_r, time_last_r;
    logic [NUM_PORTS-1:0]                first_seen_r;

    // The header source field selects the port; only even sources that fall
    // inside the port range belong to a counted MAC port.
    assign src_s      = in_data[31:16];
    assign port_s     = src_s[3:1];
    assign match_s    = (src_s[0] == 1'b0) && ({1'b0, src_s[15:1]} < 16'(NUM_PORTS));
    assign is_ioq_s   = in_wr && (state_r == ST_HDR) && (in_ctrl == IO_QUEUE_STAGE_NUM);
    assign is_ts_s    = in_wr && (state_r == ST_HDR) && (in_ctrl == TIMESTAMP_CTRL);
    assign eop_s      = in_wr && (in_ctrl != CTRL_ZERO) &&
                        ((state_r == ST_PAYLOAD) || (state_r == ST_DROP));
    assign hdr_drop_s = is_ioq_s && match_s && drop_sel_s;

    assign in_rdy   = out_rdy;
    assign out_data = out_data_r;
    assign out_ctrl = out_ctrl_r;
    assign out_wr   = out_wr_r;

    // Pick the enable/drop bits that belong to the header's source port
    always_comb begin
        drop_sel_s = 1'b0;
        en_sel_s   = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            drop_sel_s = drop_sel_s | (drop[p]   & (port_s == 3'(p)));
            en_sel_s   = en_sel_s   | (enable[p] & (port_s == 3'(p)));
        end
    end

    // Parser next-state: first ctrl==0 word opens the payload, EOP closes it
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_HDR: begin
                if (in_wr && (in_ctrl == CTRL_ZERO)) begin
                    state_nxt_s = drop_r ? ST_DROP : ST_PAYLOAD;
                end else begin
                    state_nxt_s = ST_HDR;
                end
            end
            ST_PAYLOAD, ST_DROP: begin
                if (eop_s) begin
                    state_nxt_s = ST_HDR;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: state_nxt_s = ST_HDR;
        endcase
    end

    // Parser state plus header fields that stay fixed for the whole packet
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_HDR;
            port_r      <= 3'd0;
            len_r       <= 16'd0;
            match_r     <= 1'b0;
            en_r        <= 1'b0;
            drop_r      <= 1'b0;
            hdr_valid_r <= 1'b0;
            ts_r        <= {TIME_WIDTH{1'b0}};
            ts_valid_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (is_ioq_s) begin
                port_r      <= port_s;
                len_r       <= in_data[15:0];
                match_r     <= match_s;
                en_r        <= en_sel_s;
                drop_r      <= match_s && drop_sel_s;
                hdr_valid_r <= 1'b1;
            end else if (eop_s) begin
                drop_r      <= 1'b0;
                hdr_valid_r <= 1'b0;
            end
            if (is_ts_s) begin
                ts_r       <= in_data[TIME_WIDTH-1:0];
                ts_valid_r <= 1'b1;
            end else if (eop_s) begin
                ts_valid_r <= 1'b0;
            end
        end
    end

    // One-cycle pass-through register; words of a dropped packet lose out_wr
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_data_r <= {DATA_WIDTH{1'b0}};
            out_ctrl_r <= CTRL_ZERO;
            out_wr_r   <= 1'b0;
        end else begin
            out_wr_r <= in_wr && !drop_r && !hdr_drop_s;
            if (in_wr) begin
                out_data_r <= in_data;
                out_ctrl_r <= in_ctrl;
            end
        end
    end

    // Capture the update request at EOP; a clear in that cycle discards it
    always_ff @(posedge clk) begin
        if (!reset) begin
            upd_r          <= 1'b0;
            upd_port_r     <= 3'd0;
            upd_len_r      <= 16'd0;
            upd_ts_r       <= {TIME_WIDTH{1'b0}};
            upd_ts_valid_r <= 1'b0;
        end else begin
            upd_r          <= eop_s && hdr_valid_r && match_r && en_r && !clear;
            upd_port_r     <= port_r;
            upd_len_r      <= len_r;
            upd_ts_r       <= ts_r;
            upd_ts_valid_r <= ts_valid_r;
        end
    end

    // Per-port counters and timestamps; clear beats a coincident update
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            pkt_cnt_r    <= {(NUM_PORTS*32){1'b0}};
            byte_cnt_r   <= {(NUM_PORTS*BYTE_CNT_WIDTH){1'b0}};
            time_first_r <= {(NUM_PORTS*TIME_WIDTH){1'b0}};
            time_last_r  <= {(NUM_PORTS*TIME_WIDTH){1'b0}};
            first_seen_r <= {NUM_PORTS{1'b0}};
        end else if (upd_r) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (upd_port_r == 3'(p)) begin
                    pkt_cnt_r[p*32 +: 32] <= pkt_cnt_r[p*32 +: 32] + 32'd1;
                    byte_cnt_r[p*BYTE_CNT_WIDTH +: BYTE_CNT_WIDTH] <=
                        byte_cnt_r[p*BYTE_CNT_WIDTH +: BYTE_CNT_WIDTH] + BYTE_CNT_WIDTH'(upd_len_r);
                    if (upd_ts_valid_r) begin
                        time_last_r[p*TIME_WIDTH +: TIME_WIDTH] <= upd_ts_r;
                        if (!first_seen_r[p]) begin
                            time_first_r[p*TIME_WIDTH +: TIME_WIDTH] <= upd_ts_r;
                            first_seen_r[p] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign pkt_cnt    = pkt_cnt_r;
    assign byte_cnt   = byte_cnt_r;
    assign time_first = time_first_r;
    assign time_last  = time_last_r;

`ifdef PKT_CAPTURE_MINMAX_EN
    logic [NUM_PORTS*16-1:0] min_len_r, max_len_r;

    // Running minimum and maximum packet length per port
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            min_len_r <= {NUM_PORTS{16'hffff}};
            max_len_r <= {NUM_PORTS{16'h0000}};
        end else if (upd_r) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (upd_port_r == 3'(p)) begin
                    if (upd_len_r < min_len_r[p*16 +: 16]) begin
                        min_len_r[p*16 +: 16] <= upd_len_r;
                    end
                    if (upd_len_r > max_len_r[p*16 +: 16]) begin
                        max_len_r[p*16 +: 16] <= upd_len_r;
                    end
                end
            end
        end
    end

    assign min_len = min_len_r;
    assign max_len = max_len_r;
`else
    assign min_len = {NUM_PORTS{16'hffff}};
    assign max_len = {NUM_PORTS{16'h0000}};
`endif

endmodule

// File: tb/tb_pkt_capture_stats_n.sv
// Directed bench for pkt_capture_stats_n. It covers pass-through latency,
// counting, dropping, byte-counter wrap, clear priority, back-pressure,
// reset in the middle of a packet and unmatched sources.
module tb_pkt_capture_stats_n;

    localparam int NP  = 4;
    localparam int BCW = 40;
    localparam int TW  = 64;
`ifdef PKT_CAPTURE_MINMAX_EN
    localparam bit MM = 1'b1;
`else
    localparam bit MM = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [63:0]       in_data;
    logic [7:0]        in_ctrl;
    logic              in_wr;
    logic              in_rdy;
    logic [63:0]       out_data;
    logic [7:0]        out_ctrl;
    logic              out_wr;
    logic              out_rdy;
    logic [NP-1:0]     enable;
    logic [NP-1:0]     drop;
    logic              clear;
    logic [NP*32-1:0]  pkt_cnt;
    logic [NP*BCW-1:0] byte_cnt;
    logic [NP*TW-1:0]  time_first;
    logic [NP*TW-1:0]  time_last;
    logic [NP*16-1:0]  min_len;
    logic [NP*16-1:0]  max_len;

    int errors = 0;
    int checks = 0;

    pkt_capture_stats_n dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
        .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
        .enable(enable), .drop(drop), .clear(clear),
        .pkt_cnt(pkt_cnt), .byte_cnt(byte_cnt),
        .time_first(time_first), .time_last(time_last),
        .min_len(min_len), .max_len(max_len)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input logic [63:0] d, input logic [7:0] c, input logic exp_wr, input string tag);
        in_data = d;
        in_ctrl = c;
        in_wr   = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, ".wr"}, out_wr, exp_wr);
        if (exp_wr) begin
            chk({tag, ".data"}, out_data, d);
            chk({tag, ".ctrl"}, out_ctrl, c);
        end
    endtask

    task automatic idle(input int n);
        in_wr = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // IOQ header, optional timestamp, npay-1 ctrl==0 words, EOP word
    task automatic send_pkt(input logic [15:0] src, input logic [15:0] len, input logic [63:0] ts,
                            input bit has_ts, input int npay, input logic exp_wr, input string tag);
        send_word({32'h0, src, len}, 8'hff, exp_wr, {tag, ".hdr"});
        if (has_ts) send_word(ts, 8'hfe, exp_wr, {tag, ".ts"});
        for (int i = 0; i < npay - 1; i++)
            send_word({src, 16'ha5a5, 32'(i)}, 8'h00, exp_wr, {tag, ".pl"});
        send_word({src, 16'heeee, 32'h0000eeee}, 8'h01, exp_wr, {tag, ".eop"});
        in_wr = 1'b0;
    endtask

    logic [63:0] bp_data [10];
    logic [7:0]  bp_ctrl [10];
    int          sent, rcvd, cyc;
    logic        last_wr;

    initial begin
        reset = 1'b0; in_data = 64'h1234; in_ctrl = 8'h00; in_wr = 1'b1;
        out_rdy = 1'b1; enable = 4'b0000; drop = 4'b0000; clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.out_wr", out_wr, 1'b0);
        chk("rst.out_data", out_data, 64'h0);
        chk("rst.out_ctrl", out_ctrl, 8'h0);
        chk("rst.pkt_cnt", pkt_cnt, 128'h0);
        chk("rst.byte_cnt", byte_cnt, 160'h0);
        chk("rst.min_len", min_len, {4{16'hffff}});
        chk("rst.max_len", max_len, 64'h0);
        in_wr = 1'b0;
        reset = 1'b1;
        idle(1);

        // Three counted packets on port 0 with timestamps
        enable = 4'b0001;
        send_pkt(16'd0, 16'd60,   64'd100, 1'b1, 3, 1'b1, "p0a");
        send_pkt(16'd0, 16'd1514, 64'd200, 1'b1, 4, 1'b1, "p0b");
        send_pkt(16'd0, 16'd64,   64'd300, 1'b1, 2, 1'b1, "p0c");
        idle(2);
        chk("cnt.pkt0", pkt_cnt[31:0], 32'd3);
        chk("cnt.byte0", byte_cnt[39:0], 40'd1638);
        chk("cnt.tfirst0", time_first[63:0], 64'd100);
        chk("cnt.tlast0", time_last[63:0], 64'd300);
        chk("cnt.min0", min_len[15:0], MM ? 16'd60 : 16'hffff);
        chk("cnt.max0", max_len[15:0], MM ? 16'd1514 : 16'd0);

        // Dropped but counted packet on port 2, then port 0 passes
        enable = 4'b0100; drop = 4'b0100;
        send_pkt(16'd4, 16'd100, 64'd0, 1'b1, 3, 1'b0, "drop2");
        idle(2);
        chk("drop.pkt2", pkt_cnt[95:64], 32'd1);
        chk("drop.byte2", byte_cnt[119:80], 40'd100);
        send_pkt(16'd0, 16'd64, 64'd0, 1'b0, 2, 1'b1, "after_drop");
        idle(2);
        chk("drop.pkt0_unchanged", pkt_cnt[31:0], 32'd3);

        // Byte counter wrap on port 1
        drop = 4'b0000; enable = 4'b0010;
        force dut.byte_cnt_r = {40'd0, 40'd100, 40'hff_ffff_ffce, 40'd1638};
        #1;
        release dut.byte_cnt_r;
        idle(1);
        chk("wrap.preload1", byte_cnt[79:40], 40'hff_ffff_ffce);
        send_pkt(16'd2, 16'd100, 64'd0, 1'b0, 2, 1'b1, "wrap");
        idle(2);
        chk("wrap.byte1", byte_cnt[79:40], 40'd50);
        chk("wrap.pkt1", pkt_cnt[63:32], 32'd1);

        // Clear coincides with the port 0 update
        enable = 4'b0001;
        send_pkt(16'd0, 16'd80, 64'd500, 1'b1, 2, 1'b1, "clr");
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        idle(2);
        chk("clr.pkt_cnt", pkt_cnt, 128'h0);
        chk("clr.byte_cnt", byte_cnt, 160'h0);
        chk("clr.tfirst", time_first, 256'h0);
        chk("clr.min_len", min_len, {4{16'hffff}});
        chk("clr.max_len", max_len, 64'h0);
        send_pkt(16'd0, 16'd90, 64'd700, 1'b1, 2, 1'b1, "post_clr");
        idle(2);
        chk("pclr.pkt0", pkt_cnt[31:0], 32'd1);
        chk("pclr.byte0", byte_cnt[39:0], 40'd90);
        chk("pclr.tfirst0", time_first[63:0], 64'd700);
        chk("pclr.tlast0", time_last[63:0], 64'd700);
        chk("pclr.min0", min_len[15:0], MM ? 16'd90 : 16'hffff);
        chk("pclr.max0", max_len[15:0], MM ? 16'd90 : 16'd0);

        // Ten-word packet under alternating out_rdy
        enable = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            bp_data[i] = {16'h00b0, 16'h0000, 32'(i * 17 + 3)};
            bp_ctrl[i] = (i == 9) ? 8'h01 : 8'h00;
        end
        bp_data[0] = {32'h0, 16'd6, 16'd200};
        bp_ctrl[0] = 8'hff;
        sent = 0; rcvd = 0; cyc = 0;
        while (rcvd < 10 && cyc < 60) begin
            out_rdy = cyc[0];
            #1;
            chk("bp.in_rdy", in_rdy, out_rdy);
            if (in_rdy && sent < 10) begin
                in_data = bp_data[sent];
                in_ctrl = bp_ctrl[sent];
                in_wr   = 1'b1;
                sent++;
            end else begin
                in_wr = 1'b0;
            end
            last_wr = in_wr;
            @(posedge clk);
            #1;
            chk("bp.out_wr", out_wr, last_wr);
            if (out_wr) begin
                if (rcvd < 10) chk("bp.data", out_data, bp_data[rcvd]);
                rcvd++;
            end
            cyc++;
        end
        in_wr = 1'b0; out_rdy = 1'b1;
        chk("bp.words_out", 32'(rcvd), 32'd10);

        // Reset in the middle of a counted packet
        enable = 4'b0001;
        send_word({32'h0, 16'd0, 16'd50}, 8'hff, 1'b1, "mid.hdr");
        send_word(64'h1111, 8'h00, 1'b1, "mid.pl0");
        in_data = 64'h2222; in_ctrl = 8'h00; in_wr = 1'b1; reset = 1'b0;
        @(posedge clk);
        #1;
        chk("mid.rst_out_wr", out_wr, 1'b0);
        reset = 1'b1;
        send_word(64'h3333, 8'h00, 1'b1, "mid.pl2");
        send_word(64'h4444, 8'h01, 1'b1, "mid.eop");
        idle(2);
        chk("mid.pkt_cnt", pkt_cnt, 128'h0);
        chk("mid.byte_cnt", byte_cnt, 160'h0);

        // Odd source and out-of-range source are never counted
        enable = 4'b1111;
        send_pkt(16'd3,  16'd70, 64'd900, 1'b1, 2, 1'b1, "src3");
        send_pkt(16'd10, 16'd70, 64'd901, 1'b1, 2, 1'b1, "src10");
        idle(2);
        chk("nomatch.pkt_cnt", pkt_cnt, 128'h0);
        chk("nomatch.byte_cnt", byte_cnt, 160'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pkt_capture_stats_n.md
PKT_CAPTURE_STATS_N -- requirements
Module: pkt_capture_stats_n

Interface
REQ-001 SHALL have parameters: DATA_WIDTH 64, data word width; CTRL_WIDTH DATA_WIDTH/8, ctrl width; NUM_PORTS 4, MAC ports counted (1-8); IO_QUEUE_STAGE_NUM 8'hff, module-header ctrl; TIMESTAMP_CTRL 8'hfe, timestamp-word ctrl; BYTE_CNT_WIDTH 40, byte counter width (33-64); TIME_WIDTH 64, timestamp width.
REQ-002 SHALL have ports: clk in 1 clock; reset in 1 synchronous active-low reset; in_data in DATA_WIDTH; in_ctrl in CTRL_WIDTH; in_wr in 1; in_rdy out 1; out_data out DATA_WIDTH; out_ctrl out CTRL_WIDTH; out_wr out 1; out_rdy in 1.
REQ-003 SHALL have ports: enable in NUM_PORTS, per-port count enable; drop in NUM_PORTS, per-port discard; clear in 1, single-cycle stats-clear pulse; pkt_cnt out NUM_PORTS*32; byte_cnt out NUM_PORTS*BYTE_CNT_WIDTH; time_first out NUM_PORTS*TIME_WIDTH; time_last out NUM_PORTS*TIME_WIDTH; min_len out NUM_PORTS*16; max_len out NUM_PORTS*16. Port p occupies slice [p*W +: W].

Function
REQ-004 SHALL drive in_rdy = out_rdy combinationally; a word transfers when in_wr=1; upstream SHALL NOT assert in_wr while in_rdy=0.
REQ-005 SHALL register the datapath: out_data/out_ctrl/out_wr follow accepted input with exactly 1-cycle latency; no bubbles added.
REQ-006 SHALL parse with FSM states HDR, PAYLOAD, DROP; reset state HDR.
REQ-007 HDR: word with ctrl==IO_QUEUE_STAGE_NUM latches length=data[15:0], src=data[31:16], and samples enable/drop for port p=src/2; other ctrl!=0 words stay in HDR; first ctrl==0 word -> PAYLOAD, or -> DROP when drop[p] was sampled.
REQ-008 Port match: src even and src/2 < NUM_PORTS; otherwise packet passes, is never dropped, never counted.
REQ-009 Dropped packet: out_wr=0 for every word including header words (header words held 1 cycle via the pipeline register, suppressed once drop decided at IOQ header); DROP exits to HDR after the EOP word (ctrl!=0).
REQ-010 PAYLOAD: ctrl!=0 word is EOP -> HDR; stats update the cycle after EOP when enable[p] sampled 1, including dropped packets.
REQ-011 Word with ctrl==TIMESTAMP_CTRL in HDR latches ts=data[TIME_WIDTH-1:0] and ts_valid=1; ts_valid clears at each EOP.
REQ-012 Update: pkt_cnt[p]+=1, byte_cnt[p]+=length, both modulo 2^width (wrap, no saturation); if ts_valid: time_last[p]=ts, and time_first[p]=ts when port's first_seen=0, then first_seen=1.
REQ-013 Sampled enable/drop are fixed for the whole packet; changes mid-packet take effect at the next IOQ header.
REQ-014 clear=1 zeroes all stats, first_seen, min_len to 16'hffff, max_len to 0 next cycle; clear coinciding with an update: clear wins, update discarded. Datapath and FSM unaffected by clear.
REQ-015 Stats outputs are registers, valid the cycle after update.

Reset
REQ-016 reset=0 at a rising clk edge SHALL: FSM to HDR, out_wr=0, out_data=0, out_ctrl=0, all stats as after clear, ts_valid=0.
REQ-017 Reset mid-packet SHALL abandon the packet without stat update; following words until next IOQ header are treated as HDR-state words.

Configuration
REQ-018 Macro PKT_CAPTURE_MINMAX_EN defined: per-update min_len[p]=min(min_len[p],length), max_len[p]=max(max_len[p],length).
REQ-019 Macro undefined: min/max logic absent; min_len outputs constant 16'hffff, max_len constant 0.

Verification
REQ-020 enable=4'b0001, 3 packets src=0 lengths 60,1514,64 each with timestamps 100,200,300 -> pkt_cnt0=3, byte_cnt0=1638, time_first0=100, time_last0=300, min_len0=60, max_len0=1514 (MINMAX on); output identical to input delayed 1 cycle.
REQ-021 drop=4'b0100, enable=4'b0100, packet src=4 len 100 -> no out_wr for that packet, pkt_cnt2=1, byte_cnt2=100; next packet src=0 passes unchanged.
REQ-022 byte_cnt1 preloaded near 2^40-50 via 2^N traffic (or force), packet len 100 -> byte_cnt1 wraps to 50.
REQ-023 clear pulsed on same cycle as EOP update for port 0 -> all counts 0, min_len 16'hffff; next packet counts normally, time_first set anew.
REQ-024 out_rdy toggled 0/1 every cycle during 10-word packet -> in_rdy mirrors out_rdy, no word lost or duplicated; reset asserted mid-payload -> out_wr=0 next cycle, no stat change.
REQ-025 src=3 (odd) or src=10 with NUM_PORTS=4 -> packet passes, no counter changes.
